// File: rtl/uart_rx_byte_receiver.sv
// 8N1 UART receiver: synchronises the RX pin, samples each bit at its centre and
// presents good bytes in a one-entry hold register with a valid/ready handshake.
module uart_rx_byte_receiver #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       i_Clk,
   input  logic       rst,
   input  logic       i_RX_Serial,
   output logic [7:0] o_RX_Byte,
   output logic       o_RX_Valid,
   input  logic       i_RX_Ready,
   output logic       o_Frame_Err,
   output logic       o_Overrun,
   output logic       o_Busy
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [2:0] {
      StWaitIdle,
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;

   state_e          state_q, state_d;
   logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      byte_q, byte_d;
   logic            valid_q, valid_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;
   logic            consume;

   assign rx_s    = sync_q[SYNC_STAGES-1];
   assign consume = valid_q & i_RX_Ready;

   always_ff @(posedge i_Clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_RX_Serial};
      end
   end

   always_ff @(posedge i_Clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StWaitIdle;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         byte_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         byte_q      <= byte_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      clk_cnt_d   = clk_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      byte_d      = byte_q;
      valid_d     = valid_q & ~consume;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      unique case (state_q)
         // After reset or a framing error the line must be seen high before a new start bit.
         StWaitIdle: begin
            if (rx_s) state_d = StIdle;
         end
         StIdle: begin
            if (!rx_s) begin
               state_d   = StStart;
               clk_cnt_d = '0;
            end
         end
         StStart: begin
            if (clk_cnt_q == CntHalf) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = rx_s ? StIdle : StData;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         StData: begin
            if (clk_cnt_q == CntMax) begin
               clk_cnt_d          = '0;
               shift_d[bit_idx_q] = rx_s;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (clk_cnt_q == CntMax) begin
               clk_cnt_d = '0;
               if (rx_s) begin
                  state_d = StIdle;
                  // A byte consumed this cycle frees the hold register for the new one.
                  if (!valid_q || consume) begin
                     byte_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StWaitIdle;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: state_d = StWaitIdle;
      endcase
   end

   assign o_RX_Byte   = byte_q;
   assign o_RX_Valid  = valid_q;
   assign o_Frame_Err = frame_err_q;
   assign o_Overrun   = overrun_q;
   assign o_Busy      = (state_q == StStart) || (state_q == StData) || (state_q == StStop);

endmodule

// File: tb/tb_uart_rx_byte_receiver.sv
// Bench for uart_rx_byte_receiver: drives serial frames, keeps a queue of bytes that
// must be delivered and counts error pulses, checking the DUT every cycle.
module tb_uart_rx_byte_receiver;

   localparam int CPB = 434;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Reference model: bytes that must appear at the handshake, in order.
   logic [7:0] exp_q[$];
   int         fe_cnt  = 0;
   int         ov_cnt  = 0;
   int         dlv_cnt = 0;
   logic       valid_prev = 1'b0;
   logic       ready_prev = 1'b0;
   logic [7:0] byte_prev  = 8'h00;

   uart_rx_byte_receiver #(
      .CLKS_PER_BIT(CPB),
      .SYNC_STAGES (2)
   ) dut (
      .i_Clk      (clk),
      .rst        (rst),
      .i_RX_Serial(rx),
      .o_RX_Byte  (rx_byte),
      .o_RX_Valid (rx_valid),
      .i_RX_Ready (rx_ready),
      .o_Frame_Err(frame_err),
      .o_Overrun  (overrun),
      .o_Busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one 8N1 frame; a bad stop bit is held low for one bit time.
   task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic expect_dlv);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      if (expect_dlv) exp_q.push_back(b);
      rx = stop_ok;
      tick(CPB);
      rx = 1'b1;
   endtask

   task automatic clear_counts();
      fe_cnt  = 0;
      ov_cnt  = 0;
      dlv_cnt = 0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("reset_outputs", {23'd0, rx_byte, rx_valid, frame_err, overrun, busy}, 32'd0);
         valid_prev <= 1'b0;
      end else begin
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         if (frame_err || overrun) check("pulse_exclusive", {31'd0, frame_err & overrun}, 32'd0);
         if (valid_prev && !ready_prev)
            check("hold_stable", {23'd0, rx_valid, rx_byte}, {23'd0, 1'b1, byte_prev});
         if (rx_valid && rx_ready) begin
            dlv_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_valid", {24'd0, rx_byte}, 32'hFFFF_FFFF);
            end else begin
               check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
            end
         end
         valid_prev <= rx_valid;
         ready_prev <= rx_ready;
         byte_prev  <= rx_byte;
      end
   end

   initial begin
      int exp_fe;
      rst      = 1'b0;
      rx       = 1'b1;
      rx_ready = 1'b1;
      tick(5);
      rst = 1'b1;
      tick(10);

      // 1: single byte
      clear_counts();
      send_frame(8'hAA, 1'b1, 1'b1);
      tick(CPB);
      check("t1_delivered", dlv_cnt, 1);
      check("t1_errs", {fe_cnt[15:0], ov_cnt[15:0]}, 0);
      check("t1_busy", {31'd0, busy}, 0);
      check("t1_byte_kept", {24'd0, rx_byte}, 32'hAA);
      check("t1_queue", exp_q.size(), 0);

      // 2: back-to-back with one stop bit
      clear_counts();
      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      tick(CPB);
      check("t2_delivered", dlv_cnt, 2);
      check("t2_errs", {fe_cnt[15:0], ov_cnt[15:0]}, 0);
      check("t2_queue", exp_q.size(), 0);

      // 3: overrun with consumer stalled
      clear_counts();
      rx_ready = 1'b0;
      send_frame(8'h55, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b0);
      tick(CPB);
      check("t3_overrun", ov_cnt, 1);
      check("t3_frame_err", fe_cnt, 0);
      check("t3_valid_held", {31'd0, rx_valid}, 1);
      check("t3_byte_held", {24'd0, rx_byte}, 32'h55);
      rx_ready = 1'b1;
      tick(3);
      check("t3_valid_clear", {31'd0, rx_valid}, 0);
      check("t3_delivered", dlv_cnt, 1);
      check("t3_queue", exp_q.size(), 0);

      // 4: framing error then recovery
      clear_counts();
      send_frame(8'hA5, 1'b0, 1'b0);
      tick(CPB);
      check("t4_frame_err", fe_cnt, 1);
      check("t4_no_valid", dlv_cnt, 0);
      send_frame(8'h12, 1'b1, 1'b1);
      tick(CPB);
      check("t4_delivered", dlv_cnt, 1);
      check("t4_errs_total", {fe_cnt[15:0], ov_cnt[15:0]}, 32'h0001_0000);
      check("t4_queue", exp_q.size(), 0);

      // 5: short low glitch rejected at start check
      clear_counts();
      rx = 1'b0;
      tick(100);
      rx = 1'b1;
      tick(20);
      check("t5_busy_in_start", {31'd0, busy}, 1);
      tick(200);
      check("t5_busy_after", {31'd0, busy}, 0);
      check("t5_no_valid", dlv_cnt, 0);
      check("t5_errs", {fe_cnt[15:0], ov_cnt[15:0]}, 0);

      // 6: reset during bit 4 of 0x77
      clear_counts();
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = (i == 3) ? 1'b0 : 1'b1;
         tick(CPB);
      end
      rx = 1'b1;
      tick(200);
      rst = 1'b0;
      tick(5);
      rx = 1'b1;
      tick(5);
      rst = 1'b1;
      tick(CPB);
      check("t6_no_partial", dlv_cnt, 0);
      check("t6_busy", {31'd0, busy}, 0);
      check("t6_valid", {31'd0, rx_valid}, 0);
      send_frame(8'hC3, 1'b1, 1'b1);
      tick(CPB);
      check("t6_delivered", dlv_cnt, 1);
      check("t6_errs", {fe_cnt[15:0], ov_cnt[15:0]}, 0);
      check("t6_queue", exp_q.size(), 0);

      // Randomized frames, occasional bad stop bits and glitches
      clear_counts();
      exp_fe = 0;
      for (int n = 0; n < 5; n++) begin
         logic [7:0] b;
         logic       ok;
         b  = 8'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 2) == 0) begin
            rx = 1'b0;
            tick($urandom_range(10, 150));
            rx = 1'b1;
            tick(300);
         end
         send_frame(b, ok, ok);
         if (!ok) exp_fe++;
         tick($urandom_range(1, CPB));
      end
      tick(CPB);
      check("rand_frame_err", fe_cnt, exp_fe);
      check("rand_overrun", ov_cnt, 0);
      check("rand_queue", exp_q.size(), 0);
      check("rand_busy", {31'd0, busy}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
